// File: rtl/adc_pkg.sv
// Shared constants, state encoding and frame-slot helper for the ADC reader.
// ADC_AMP_GAIN_EN (optional) enables the AMP state in adc_reader.
package adc_pkg;
   localparam int ADC_BITS  = 14;
   localparam int FRAME_LEN = 34;
   localparam int CH0_FIRST = 2;
   localparam int CH1_FIRST = 18;
   localparam int AMP_BITS  = 8;
   localparam int BIT_CNT_W = 6;

   typedef enum logic [2:0] {
      IDLE,
      CONV,
      SHIFT,
      DONE,
      AMP
   } state_t;

   // True when frame bit b belongs to the channel whose MSB sits at slot first.
   function automatic logic in_window(input logic [BIT_CNT_W-1:0] b, input int first);
      return (int'(b) >= first) && (int'(b) < first + ADC_BITS);
   endfunction
endpackage

// File: rtl/adc_reader_if.sv
// Signal bundle between the ADC reader (master) and the ADC/front-end (slave).
// ADC_AMP_GAIN_EN adds the preamp gain-load signals.
interface adc_reader_if;
   import adc_pkg::*;

   logic                start;
   logic                SPI_MISO;
   logic                SPI_SCK;
   logic                AD_CONV;
   logic [ADC_BITS-1:0] V_0;
   logic [ADC_BITS-1:0] V_1;
   logic                valid;
   logic                busy;
`ifdef ADC_AMP_GAIN_EN
   logic [3:0]          gain_A;
   logic [3:0]          gain_B;
   logic                gain_load;
   logic                AMP_CS;
   logic                SPI_MOSI;

   modport master (
      input  start, SPI_MISO, gain_A, gain_B, gain_load,
      output SPI_SCK, AD_CONV, V_0, V_1, valid, busy, AMP_CS, SPI_MOSI
   );
   modport slave (
      output start, SPI_MISO, gain_A, gain_B, gain_load,
      input  SPI_SCK, AD_CONV, V_0, V_1, valid, busy, AMP_CS, SPI_MOSI
   );
`else
   modport master (
      input  start, SPI_MISO,
      output SPI_SCK, AD_CONV, V_0, V_1, valid, busy
   );
   modport slave (
      output start, SPI_MISO,
      input  SPI_SCK, AD_CONV, V_0, V_1, valid, busy
   );
`endif
endinterface

// File: rtl/adc_sck_gen.sv
// SPI clock divider: SCK_HALF clk cycles per half period, with one-cycle
// rise/fall ticks that coincide with the registered SCK edges.
module adc_sck_gen #(
   parameter int SCK_HALF = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_sck_oe,
   output logic o_sck,
   output logic o_rise_tick,
   output logic o_fall_tick
);
   localparam int CNT_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_phase;
   logic             r_sck;
   logic             w_wrap;

   assign w_wrap      = i_en && (r_cnt == CNT_W'(SCK_HALF - 1));
   assign o_rise_tick = w_wrap && !r_phase;
   assign o_fall_tick = w_wrap && r_phase;
   assign o_sck       = r_sck;

   // The phase keeps running while the pin is masked, so CONV timing shares the divider.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
         r_sck   <= 1'b0;
      end else if (!i_en) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
         r_sck   <= 1'b0;
      end else if (w_wrap) begin
         r_cnt   <= '0;
         r_phase <= ~r_phase;
         r_sck   <= i_sck_oe & ~r_phase;
      end else begin
         r_cnt   <= r_cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/adc_reader.sv
// SPI master for a dual-channel 14-bit ADC: AD_CONV pulse, 34-bit frame in,
// both channels out with a valid strobe. ADC_AMP_GAIN_EN adds a preamp gain-load state.
module adc_reader #(
   parameter int SCK_HALF  = 4,
   parameter int FRAME_LEN = adc_pkg::FRAME_LEN
) (
   input logic          CLK_50M,
   input logic          RESET_N,
   adc_reader_if.master adc
);
   import adc_pkg::*;

   state_t                r_state;
   state_t                w_state_next;
   logic [BIT_CNT_W-1:0]  r_bit;
   logic [ADC_BITS-1:0]   r_ch0;
   logic [ADC_BITS-1:0]   r_ch1;
   logic [ADC_BITS-1:0]   r_v0;
   logic [ADC_BITS-1:0]   r_v1;
   logic                  r_valid;
   logic                  r_ad_conv;
   logic                  w_div_en;
   logic                  w_sck_oe;
   logic                  w_rise;
   logic                  w_fall;

   assign w_div_en = (r_state == CONV) || (r_state == SHIFT) || (r_state == AMP);
   assign w_sck_oe = (r_state == SHIFT) || (r_state == AMP);

   adc_sck_gen #(
      .SCK_HALF (SCK_HALF)
   ) u_sck_gen (
      .i_clk       (CLK_50M),
      .i_rst_n     (RESET_N),
      .i_en        (w_div_en),
      .i_sck_oe    (w_sck_oe),
      .o_sck       (adc.SPI_SCK),
      .o_rise_tick (w_rise),
      .o_fall_tick (w_fall)
   );

`ifdef ADC_AMP_GAIN_EN
   logic                  r_gain_pend;
   logic                  r_amp_cs;
   logic [AMP_BITS-1:0]   r_amp_sh;
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
`ifdef ADC_AMP_GAIN_EN
            if (r_gain_pend)    w_state_next = AMP;
            else if (adc.start) w_state_next = CONV;
`else
            if (adc.start)      w_state_next = CONV;
`endif
         end
         CONV:  if (w_fall) w_state_next = SHIFT;
         SHIFT: if (w_fall && (r_bit == BIT_CNT_W'(FRAME_LEN - 1))) w_state_next = DONE;
         DONE:  w_state_next = IDLE;
`ifdef ADC_AMP_GAIN_EN
         AMP:   if (w_fall && (r_bit == BIT_CNT_W'(AMP_BITS - 1))) w_state_next = IDLE;
`endif
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK_50M or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state   <= IDLE;
         r_bit     <= '0;
         r_ch0     <= '0;
         r_ch1     <= '0;
         r_v0      <= '0;
         r_v1      <= '0;
         r_valid   <= 1'b0;
         r_ad_conv <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_ad_conv <= (w_state_next == CONV);
         r_valid   <= (r_state == DONE);
         if ((r_state != SHIFT) && (r_state != AMP)) r_bit <= '0;
         else if (w_fall)                             r_bit <= r_bit + BIT_CNT_W'(1);
         // Guard and trailing bits fall outside both windows and are dropped.
         if ((r_state == SHIFT) && w_rise) begin
            if (in_window(r_bit, CH0_FIRST)) r_ch0 <= {r_ch0[ADC_BITS-2:0], adc.SPI_MISO};
            if (in_window(r_bit, CH1_FIRST)) r_ch1 <= {r_ch1[ADC_BITS-2:0], adc.SPI_MISO};
         end
         if (r_state == DONE) begin
            r_v0 <= r_ch0;
            r_v1 <= r_ch1;
         end
      end
   end

`ifdef ADC_AMP_GAIN_EN
   // Pending gain load starts set so the preamp is programmed once after reset.
   always_ff @(posedge CLK_50M or negedge RESET_N) begin
      if (!RESET_N) begin
         r_gain_pend <= 1'b1;
         r_amp_cs    <= 1'b1;
         r_amp_sh    <= '0;
      end else begin
         if (adc.gain_load)       r_gain_pend <= 1'b1;
         else if (r_state == IDLE) r_gain_pend <= 1'b0;
         r_amp_cs <= (w_state_next != AMP);
         if ((r_state != AMP) && (w_state_next == AMP)) r_amp_sh <= {adc.gain_B, adc.gain_A};
         else if ((r_state == AMP) && w_fall)          r_amp_sh <= {r_amp_sh[AMP_BITS-2:0], 1'b0};
      end
   end

   assign adc.AMP_CS   = r_amp_cs;
   assign adc.SPI_MOSI = r_amp_sh[AMP_BITS-1];
`endif

   assign adc.AD_CONV = r_ad_conv;
   assign adc.V_0     = r_v0;
   assign adc.V_1     = r_v1;
   assign adc.valid   = r_valid;
   assign adc.busy    = (r_state != IDLE);
endmodule

// File: tb/tb_adc_reader.sv
// Directed bench for adc_reader: behavioural LTC1407A-style MISO model plus
// per-scenario tasks with hand-computed expectations.
module tb_adc_reader;
   logic clk = 1'b0;
   logic rst_n;
   always #10 clk = ~clk;

   adc_reader_if bus();

   adc_reader #(
      .SCK_HALF  (4),
      .FRAME_LEN (34)
   ) dut (
      .CLK_50M (clk),
      .RESET_N (rst_n),
      .adc     (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int sck_rises   = 0;
   int conv_rises  = 0;
   int conv_cycles = 0;
   int          vedge[$];
   logic [13:0] vq0[$];
   logic [13:0] vq1[$];
   logic [13:0] q0[$];
   logic [13:0] q1[$];
   logic [13:0] cur0 = 14'h0;
   logic [13:0] cur1 = 14'h0;
   int          midx = 0;

`ifdef ADC_AMP_GAIN_EN
   initial begin
      bus.gain_A = 4'h0;
      bus.gain_B = 4'h0;
      bus.gain_load = 1'b0;
   end
`endif

   initial forever begin @(posedge clk); cyc++; end
   initial forever begin @(posedge bus.SPI_SCK); sck_rises++; end
   initial forever begin @(posedge bus.AD_CONV); conv_rises++; end

   // vedge holds the clock edge at which a consumer would sample valid high.
   initial forever begin
      @(negedge clk);
      if (bus.AD_CONV === 1'b1) conv_cycles++;
      if (bus.valid === 1'b1) begin
         vedge.push_back(cyc + 1);
         vq0.push_back(bus.V_0);
         vq1.push_back(bus.V_1);
         $display("frame: edge=%0d V_0=%h V_1=%h", cyc + 1, bus.V_0, bus.V_1);
      end
   end

   // ADC frame: bits 2..15 ch0 MSB first, 18..31 ch1 MSB first, all others 1.
   function automatic logic frame_bit(input int b);
      if (b >= 2 && b <= 15)  return cur0[15 - b];
      if (b >= 18 && b <= 31) return cur1[31 - b];
      return 1'b1;
   endfunction

   initial begin
      bus.SPI_MISO = 1'b1;
      forever begin
         @(posedge bus.AD_CONV or negedge bus.SPI_SCK);
         if (bus.AD_CONV === 1'b1) begin
            midx = 0;
            if (q0.size() > 0) begin
               cur0 = q0.pop_front();
               cur1 = q1.pop_front();
            end
         end else begin
            midx++;
         end
         bus.SPI_MISO = frame_bit(midx);
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_valids(input int n, input int bound);
      for (int i = 0; i < bound && vedge.size() < n; i++) @(negedge clk);
   endtask

   task automatic kick(output int k);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 k = cyc;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.start = 1'b1;
      wait_cycles(5);
      total++; if (bus.SPI_SCK !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b exp=0", bus.SPI_SCK); end
      total++; if (bus.AD_CONV !== 1'b0) begin bad++; $display("FAIL reset_adconv got=%b exp=0", bus.AD_CONV); end
      total++; if (bus.V_0 !== 14'h0) begin bad++; $display("FAIL reset_v0 got=%h exp=0", bus.V_0); end
      total++; if (bus.V_1 !== 14'h0) begin bad++; $display("FAIL reset_v1 got=%h exp=0", bus.V_1); end
      total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL release_busy got=%b exp=1", bus.busy); end
      total++; if (bus.AD_CONV !== 1'b1) begin bad++; $display("FAIL release_adconv got=%b exp=1", bus.AD_CONV); end
      @(negedge clk);
      rst_n = 1'b0;
      bus.start = 1'b0;
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(2);
   endtask

   task automatic test_single_frame;
      int k, vb, sb, cb;
      q0.push_back(14'h2AAA);
      q1.push_back(14'h1555);
      vb = vedge.size(); sb = sck_rises; cb = conv_cycles;
      kick(k);
      @(negedge clk);
      bus.start = 1'b0;
      wait_valids(vb + 1, 400);
      wait_cycles(300);
      total++; if (vedge.size() - vb !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", vedge.size() - vb); end
      if (vedge.size() > vb) begin
         total++; if (vedge[vb] !== k + 282) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", vedge[vb] - k, 282); end
         total++; if (vq0[vb] !== 14'h2AAA) begin bad++; $display("FAIL single_v0 got=%h exp=2aaa", vq0[vb]); end
         total++; if (vq1[vb] !== 14'h1555) begin bad++; $display("FAIL single_v1 got=%h exp=1555", vq1[vb]); end
      end
      total++; if (conv_cycles - cb !== 8) begin bad++; $display("FAIL single_adconv_len got=%0d exp=8", conv_cycles - cb); end
      total++; if (sck_rises - sb !== 34) begin bad++; $display("FAIL single_sck_rises got=%0d exp=34", sck_rises - sb); end
      total++; if (bus.V_0 !== 14'h2AAA) begin bad++; $display("FAIL single_hold_v0 got=%h exp=2aaa", bus.V_0); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_back_to_back;
      int k, vb;
      logic [13:0] e0 [3];
      logic [13:0] e1 [3];
      e0[0] = 14'h3FFF; e0[1] = 14'h0000; e0[2] = 14'h2001;
      e1[0] = 14'h0123; e1[1] = 14'h3ABC; e1[2] = 14'h1000;
      for (int i = 0; i < 3; i++) begin
         q0.push_back(e0[i]);
         q1.push_back(e1[i]);
      end
      vb = vedge.size();
      kick(k);
      while (cyc < k + 2 * 282 + 10) @(negedge clk);
      bus.start = 1'b0;
      wait_valids(vb + 3, 600);
      wait_cycles(300);
      total++; if (vedge.size() - vb !== 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", vedge.size() - vb); end
      for (int i = 0; i < 3 && vb + i < vedge.size(); i++) begin
         total++; if (vedge[vb + i] !== k + 282 * (i + 1)) begin bad++; $display("FAIL b2b_edge%0d got=%0d exp=%0d", i, vedge[vb + i] - k, 282 * (i + 1)); end
         total++; if (vq0[vb + i] !== e0[i]) begin bad++; $display("FAIL b2b_v0_%0d got=%h exp=%h", i, vq0[vb + i], e0[i]); end
         total++; if (vq1[vb + i] !== e1[i]) begin bad++; $display("FAIL b2b_v1_%0d got=%h exp=%h", i, vq1[vb + i], e1[i]); end
      end
   endtask

   task automatic test_start_busy;
      int k, vb, cr;
      q0.push_back(14'h0F0F);
      q1.push_back(14'h30C3);
      vb = vedge.size(); cr = conv_rises;
      kick(k);
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < k + 50) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < k + 200) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_valids(vb + 1, 400);
      wait_cycles(400);
      total++; if (vedge.size() - vb !== 1) begin bad++; $display("FAIL busy_valid_count got=%0d exp=1", vedge.size() - vb); end
      total++; if (conv_rises - cr !== 1) begin bad++; $display("FAIL busy_conv_count got=%0d exp=1", conv_rises - cr); end
      if (vedge.size() > vb) begin
         total++; if (vq0[vb] !== 14'h0F0F) begin bad++; $display("FAIL busy_v0 got=%h exp=0f0f", vq0[vb]); end
      end
   endtask

   task automatic test_reset_mid;
      int k, vb, sb;
      q0.push_back(14'h1234);
      q1.push_back(14'h0ABC);
      vb = vedge.size(); sb = sck_rises;
      kick(k);
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 400 && sck_rises - sb < 21; i++) @(negedge clk);
      total++; if (sck_rises - sb !== 21) begin bad++; $display("FAIL mid_reach_p20 got=%0d exp=21", sck_rises - sb); end
      #3 rst_n = 1'b0;
      #1;
      total++; if (bus.SPI_SCK !== 1'b0) begin bad++; $display("FAIL mid_sck got=%b exp=0", bus.SPI_SCK); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
      total++; if (bus.V_0 !== 14'h0) begin bad++; $display("FAIL mid_v0 got=%h exp=0", bus.V_0); end
      total++; if (bus.V_1 !== 14'h0) begin bad++; $display("FAIL mid_v1 got=%h exp=0", bus.V_1); end
      wait_cycles(3);
      rst_n = 1'b1;
      wait_cycles(300);
      total++; if (vedge.size() - vb !== 0) begin bad++; $display("FAIL mid_no_valid got=%0d exp=0", vedge.size() - vb); end
      q0.push_back(14'h2345);
      q1.push_back(14'h1ABC);
      vb = vedge.size();
      kick(k);
      @(negedge clk);
      bus.start = 1'b0;
      wait_valids(vb + 1, 400);
      wait_cycles(20);
      total++; if (vedge.size() - vb !== 1) begin bad++; $display("FAIL after_count got=%0d exp=1", vedge.size() - vb); end
      if (vedge.size() > vb) begin
         total++; if (vedge[vb] !== k + 282) begin bad++; $display("FAIL after_latency got=%0d exp=282", vedge[vb] - k); end
         total++; if (vq0[vb] !== 14'h2345) begin bad++; $display("FAIL after_v0 got=%h exp=2345", vq0[vb]); end
         total++; if (vq1[vb] !== 14'h1ABC) begin bad++; $display("FAIL after_v1 got=%h exp=1abc", vq1[vb]); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0;
      test_reset;
      test_single_frame;
      test_back_to_back;
      test_start_busy;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/adc_reader.md
Name: adc_reader

Overview:
- SPI master that reads the dual-channel 14-bit ADC (LTC1407A-1 style) feeding the lock-in front end.
- Receive-side counterpart of the DAC driver: it pulses AD_CONV, clocks a 34-bit frame in on SPI_MISO and presents both channels as signed samples with a one-cycle valid strobe.
- The top level muxes SPI_SCK between this block and the DAC driver using `busy`.

Parameters:
- SCK_HALF, 4, CLK_50M cycles per SPI_SCK half-period (4 gives 6.25 MHz SCK).
- FRAME_LEN, 34, SCK periods per ADC frame.

Ports:
- CLK_50M  input  1  system clock, 50 MHz.
- RESET_N  input  1  asynchronous active-low reset.
- start  input  1  conversion request, level-sampled in IDLE.
- SPI_MISO  input  1  ADC serial data.
- SPI_SCK  output  1  SPI clock, low when idle.
- AD_CONV  output  1  conversion strobe to ADC.
- V_0  output  14  channel 0 sample, two's complement.
- V_1  output  14  channel 1 sample, two's complement.
- valid  output  1  one-cycle strobe when V_0/V_1 update.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - All outputs 0; FSM to IDLE; counters cleared.
  - Reset mid-frame aborts immediately, with no valid and no output update.
- SCK tick: a divider counts 0..SCK_HALF-1 and toggles an internal phase.
  - rise_tick marks each SCK rising edge; fall_tick marks each falling edge.
  - The divider runs only in CONV/SHIFT and is cleared in IDLE.
- FSM states: IDLE, CONV, SHIFT, DONE.
  - IDLE: SPI_SCK=0, AD_CONV=0. If start=1 at a clock edge, go to CONV.
  - CONV: AD_CONV=1 for exactly 2*SCK_HALF cycles, SCK held low; then go to SHIFT.
  - SHIFT: SPI_SCK toggles every SCK_HALF cycles, starting low, for FRAME_LEN full periods.
    - SPI_MISO is sampled on each SCK rising edge; bit index b counts 0..33.
    - Bits 2..15 go to a ch0 shift register, MSB first.
    - Bits 18..31 go to a ch1 shift register, MSB first.
    - Bits 0, 1, 16, 17, 32 and 33 are discarded.
    - After the falling edge that ends period 33, go to DONE.
  - DONE: V_0/V_1 load from the shift registers, valid=1 for one cycle, go to IDLE.
- Timing:
  - Latency: start sampled at edge k, valid high in cycle k+2+70*SCK_HALF (k+282 at default).
  - With start held high, frames run back-to-back: 70*SCK_HALF+2 cycles each (282 cycles = 5.64 us).
- start is ignored while busy=1; requests are not queued.
- V_0 and V_1 hold their values between valid strobes. There is no sign extension; the raw ADC two's-complement word is passed through.
- SPI_SCK and AD_CONV are driven from registers and are glitch-free.

Optional Feature:
- ADC_AMP_GAIN_EN: adds a programmable preamp gain-load path.
- Additional ports:
  - gain_A [3:0] input, gain_B [3:0] input.
  - gain_load input.
  - AMP_CS output (reset 1).
  - SPI_MOSI output (reset 0).
- Extra state AMP, entered from IDLE:
  - Entered when a gain_load request is pending; gain_load has priority over start.
  - Entered automatically once after reset.
  - AMP_CS=0; the byte {gain_B, gain_A} is shifted out MSB first.
  - MOSI changes on SCK falling edges; 8 SCK periods, then AMP_CS=1 and return to IDLE.
- gain_load is latched as a pending request if it arrives while busy.
- Without the macro, these ports and the AMP state do not exist.

Decomposition:
- Package adc_pkg holds:
  - ADC_BITS=14, FRAME_LEN=34, CH0_FIRST=2, CH1_FIRST=18, AMP_BITS=8.
  - The state encoding typedef (IDLE, CONV, SHIFT, DONE, AMP).
- Sub-module adc_sck_gen: parameterised SCK divider that outputs SPI_SCK, rise_tick, fall_tick and an enable input.

Test Plan:
- Reset: hold RESET_N=0 with start=1 → all outputs 0, busy=0; release → CONV begins next cycle.
- Single frame: MISO model returns ch0=14'h2AAA, ch1=14'h1555, junk=1 on discarded bits → valid once at k+282, V_0=14'h2AAA, V_1=14'h1555, AD_CONV high exactly 8 cycles, 34 SCK rising edges.
- Back-to-back: start held high for 3 frames with ch0 values 14'h3FFF, 14'h0000, 14'h2001 → 3 valid strobes spaced 282 cycles, values in order.
- Start while busy: pulse start at cycles 50 and 200 of a frame → exactly one frame, one valid.
- Reset mid-frame: assert RESET_N=0 at SCK period 20 → no valid, V_0/V_1=0, SPI_SCK=0 immediately; next frame after release is correct.
- With ADC_AMP_GAIN_EN: gain_A=4'h1, gain_B=4'h1, gain_load pulse → AMP_CS low for 8 SCK periods, MOSI=8'h11 MSB first; a start pending during AMP is serviced afterwards.
